alu_mdu: RTL and testbench
==========================

Name: alu_mdu

Overview:
- Parametrised successor to the single-cycle datapath ALU.
- Adds a registered result with a valid/ready handshake, signed/unsigned compares, a true arithmetic right shift, and an iterative multiply/divide engine with HI/LO registers.
- Sits in the EX stage; the hazard unit stalls the pipeline on `in_ready`.

Parameters:
- `WIDTH`, 32, datapath width in bits (even, ≥8).
- `SHW`, `$clog2(WIDTH)`, shift-amount width.
- `CNTW`, `$clog2(WIDTH+1)`, iteration counter width.

Ports:
- `clk` input 1: rising-edge clock.
- `rst` input 1: synchronous, active-high reset.
- `in_valid` input 1: operation request.
- `in_ready` output 1: unit can accept; a transfer occurs when `in_valid` & `in_ready` at an edge.
- `alu_ctrl` input 5: opcode.
- `a` input WIDTH: operand A / dividend / multiplicand.
- `b` input WIDTH: operand B / divisor / shift source.
- `shamt` input SHW: shift amount.
- `out_valid` output 1: one-cycle pulse; result valid.
- `out_result` output WIDTH: registered result.
- `out_zero` output 1: registered, (`out_result` == 0).
- `busy` output 1: mul/div in progress.
- `ovf` output 1: present only with `ALU_OVF_EN`.

Behaviour:
- Reset: `out_result`=0, `out_zero`=1, `out_valid`=0, `busy`=0, HI=LO=0, state IDLE, so `in_ready`=1 in the cycle after reset.
- Reset mid-operation aborts the op: no `out_valid`, HI/LO cleared.
- Opcodes:
  - 0 AND, 1 OR, 2 ADD, 6 SUB.
  - 7 SLTU (unsigned a<b → 1, else 0), 8 SLT (signed).
  - 11 SRA (b arithmetic >> shamt), 12 NOR, 13 XNOR, 14 SLL (b<<shamt), 15 SRL (b logical >> shamt).
  - 16 LUI (b << WIDTH/2).
  - 17 MULT, 18 MULTU, 19 DIV, 20 DIVU.
  - 21 MFHI, 22 MFLO, 23 MTHI (HI←a, result a), 24 MTLO (LO←a, result a).
  - All other codes: result 0.
- ADD/SUB wrap modulo 2^WIDTH.
- Single-cycle ops (all except 17–20):
  - Result is registered on the accepting edge; `out_valid`=1 the next cycle.
  - `in_ready` stays 1, so back-to-back issue yields one result per cycle.
- State machine IDLE → ITER → FIN → IDLE, used for opcodes 17–20.
  - The accepting edge latches operands, converts to magnitudes for signed ops, loads `cnt`=WIDTH, and enters ITER. `busy`=1 and `in_ready`=0 from then on.
  - ITER: one shift-add (mul) or restoring subtract-shift (div) step per cycle; `cnt` decrements; leave ITER when `cnt` reaches 1 after its step.
  - FIN: applies sign correction, writes HI/LO, sets `out_result`=LO and `out_valid`=1 for the next cycle, and returns to IDLE. `in_ready`=1 during that `out_valid` cycle.
  - Total latency: `out_valid` is high in the cycle following edge accept+WIDTH+1, i.e. WIDTH+2 cycles after accept.
- MULT/MULTU: {HI,LO} = full 2·WIDTH product. For signed, the product is negated iff the operand signs differ.
- DIV/DIVU: LO=quotient, HI=remainder.
  - Signed: quotient sign = sa^sb; remainder takes the sign of the dividend.
  - Most-negative ÷ −1: LO = most-negative, HI = 0.
- Divide by zero: LO = all ones, HI = `a` (raw); full latency is still spent.
- `in_valid` while `in_ready`=0 is ignored; the request is not queued.
- MFHI/MFLO issued in the cycle `out_valid` from a mul/div is high see the new HI/LO.
- `out_zero` always tracks the registered `out_result`.

Optional Feature:
- `ALU_OVF_EN` defined:
  - Port `ovf` exists.
  - Registered with the result: 1 on signed overflow of ADD (operand signs equal, result sign differs) or SUB (operand signs differ, result sign ≠ a's sign); 0 for every other op.
  - Reset value 0.
  - `out_result` is still the wrapped value.
- Undefined: no `ovf` port, no overflow logic.

Decomposition:
- Package `alu_pkg`: the 5-bit opcode localparams, FSM state encodings (IDLE/ITER/FIN), and the divide-by-zero quotient constant.
- Sub-module `alu_muldiv_seq` holds the iterative engine: a start/done interface, `cnt`, a 2·WIDTH accumulator, and sign fix-up.
- The top level holds the combinational op mux, HI/LO, and the handshake.

Test Plan:
- Reset, then ADD a=7, b=0xFFFFFFF9 → `out_result`=0, `out_zero`=1, `out_valid` one cycle after accept.
- Back-to-back SLT a=0xFFFFFFFF, b=1 then SLTU with the same operands → results 1 then 0 on consecutive cycles.
- SRA b=0x80000000, shamt=4 → 0xF8000000; SRL with the same inputs → 0x08000000.
- MULT a=−3, b=5 → `in_ready` low for WIDTH+1 cycles, `out_valid` at accept+34, LO=0xFFFFFFF1, HI=0xFFFFFFFF; MFHI next → 0xFFFFFFFF.
- DIV a=−7, b=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU a=9, b=0 → LO=0xFFFFFFFF, HI=9.
- Assert `rst` at cycle 10 of a DIVU → no `out_valid`, HI=LO=0, `in_ready`=1 next cycle. With `ALU_OVF_EN`: ADD 0x7FFFFFFF+1 → `ovf`=1, result 0x80000000.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode, FSM-state and constant definitions for the alu_mdu datapath.
package alu_pkg;

   localparam logic [4:0] OP_AND   = 5'd0;
   localparam logic [4:0] OP_OR    = 5'd1;
   localparam logic [4:0] OP_ADD   = 5'd2;
   localparam logic [4:0] OP_SUB   = 5'd6;
   localparam logic [4:0] OP_SLTU  = 5'd7;
   localparam logic [4:0] OP_SLT   = 5'd8;
   localparam logic [4:0] OP_SRA   = 5'd11;
   localparam logic [4:0] OP_NOR   = 5'd12;
   localparam logic [4:0] OP_XNOR  = 5'd13;
   localparam logic [4:0] OP_SLL   = 5'd14;
   localparam logic [4:0] OP_SRL   = 5'd15;
   localparam logic [4:0] OP_LUI   = 5'd16;
   localparam logic [4:0] OP_MULT  = 5'd17;
   localparam logic [4:0] OP_MULTU = 5'd18;
   localparam logic [4:0] OP_DIV   = 5'd19;
   localparam logic [4:0] OP_DIVU  = 5'd20;
   localparam logic [4:0] OP_MFHI  = 5'd21;
   localparam logic [4:0] OP_MFLO  = 5'd22;
   localparam logic [4:0] OP_MTHI  = 5'd23;
   localparam logic [4:0] OP_MTLO  = 5'd24;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_ITER = 2'd1;
   localparam logic [1:0] ST_FIN  = 2'd2;

   // Every quotient bit is set when dividing by zero.
   localparam logic DIVZ_Q_BIT = 1'b1;

   function automatic logic is_muldiv(input logic [4:0] op);
      return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
   endfunction

endpackage

// File: rtl/alu_muldiv_seq.sv
// Iterative multiply/divide engine: shift-add multiply, restoring divide, sign fix-up.
module alu_muldiv_seq
   import alu_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNTW  = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [4:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   logic [1:0]         state;
   logic [CNTW-1:0]    cnt;
   logic [2*WIDTH-1:0] acc;
   logic [2*WIDTH-1:0] acc_step;
   logic [2*WIDTH-1:0] prod;
   logic [WIDTH-1:0]   ma, mb, raw_a;
   logic [WIDTH-1:0]   ma_c, mb_c, quo, rem;
   logic               is_div, neg_q, neg_r, divz;
   logic               sgn, sa, sb, st_div;
   logic [WIDTH:0]     mul_sum, srem, sdiff;
   logic               ge;

   always_comb begin
      st_div = (op == OP_DIV) || (op == OP_DIVU);
      sgn    = (op == OP_MULT) || (op == OP_DIV);
      sa     = sgn & a[WIDTH-1];
      sb     = sgn & b[WIDTH-1];
      ma_c   = sa ? -a : a;
      mb_c   = sb ? -b : b;
   end

   // Divide keeps a (WIDTH+1)-bit partial remainder so the bit shifted out of acc is not lost.
   always_comb begin
      mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, ma} : '0);
      srem     = acc[2*WIDTH-1:WIDTH-1];
      ge       = (srem >= {1'b0, mb});
      sdiff    = srem - {1'b0, mb};
      acc_step = is_div ? {(ge ? sdiff[WIDTH-1:0] : srem[WIDTH-1:0]), acc[WIDTH-2:0], ge}
                        : {mul_sum, acc[WIDTH-1:1]};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= ST_IDLE;
         cnt    <= '0;
         acc    <= '0;
         ma     <= '0;
         mb     <= '0;
         raw_a  <= '0;
         is_div <= 1'b0;
         neg_q  <= 1'b0;
         neg_r  <= 1'b0;
         divz   <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  ma     <= ma_c;
                  mb     <= mb_c;
                  raw_a  <= a;
                  is_div <= st_div;
                  neg_q  <= sa ^ sb;
                  neg_r  <= sa;
                  divz   <= st_div && (b == '0);
                  acc    <= {{WIDTH{1'b0}}, (st_div ? ma_c : mb_c)};
                  cnt    <= CNTW'(WIDTH);
                  state  <= ST_ITER;
               end
            end
            ST_ITER: begin
               acc <= acc_step;
               cnt <= cnt - 1'b1;
               if (cnt == CNTW'(1)) state <= ST_FIN;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   always_comb begin
      prod = neg_q ? -acc : acc;
      quo  = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
      rem  = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
      if (!is_div) begin
         hi = prod[2*WIDTH-1:WIDTH];
         lo = prod[WIDTH-1:0];
      end else if (divz) begin
         hi = raw_a;
         lo = {WIDTH{DIVZ_Q_BIT}};
      end else begin
         hi = rem;
         lo = quo;
      end
   end

   assign busy = (state != ST_IDLE);
   assign done = (state == ST_FIN);

endmodule

// File: rtl/alu_mdu.sv
// EX-stage ALU with registered result, valid/ready handshake and HI/LO mul/div unit.
// Optional signed-overflow flag port `ovf` is built when ALU_OVF_EN is defined.
module alu_mdu
   import alu_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int SHW   = $clog2(WIDTH),
   parameter int CNTW  = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [4:0]       alu_ctrl,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [SHW-1:0]   shamt,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_result,
   output logic             out_zero,
   output logic             busy
`ifdef ALU_OVF_EN
   ,
   output logic             ovf
`endif
);

   logic [WIDTH-1:0] hi_q, lo_q;
   logic [WIDTH-1:0] res, sum, diff, sra_res;
   logic [WIDTH-1:0] eng_hi, eng_lo;
   logic             eng_busy, eng_done;
   logic             accept, md_op, single;

   assign in_ready = ~eng_busy;
   assign busy     = eng_busy;
   assign accept   = in_valid & in_ready;
   assign md_op    = is_muldiv(alu_ctrl);
   assign single   = accept & ~md_op;

   alu_muldiv_seq #(
      .WIDTH (WIDTH),
      .CNTW  (CNTW)
   ) u_seq (
      .clk   (clk),
      .rst   (rst),
      .start (accept & md_op),
      .op    (alu_ctrl),
      .a     (a),
      .b     (b),
      .busy  (eng_busy),
      .done  (eng_done),
      .hi    (eng_hi),
      .lo    (eng_lo)
   );

   always_comb begin
      sum     = a + b;
      diff    = a - b;
      sra_res = $signed(b) >>> shamt;
      case (alu_ctrl)
         OP_AND:  res = a & b;
         OP_OR:   res = a | b;
         OP_ADD:  res = sum;
         OP_SUB:  res = diff;
         OP_SLTU: res = {{(WIDTH-1){1'b0}}, (a < b)};
         OP_SLT:  res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
         OP_SRA:  res = sra_res;
         OP_NOR:  res = ~(a | b);
         OP_XNOR: res = ~(a ^ b);
         OP_SLL:  res = b << shamt;
         OP_SRL:  res = b >> shamt;
         OP_LUI:  res = b << (WIDTH / 2);
         OP_MFHI: res = hi_q;
         OP_MFLO: res = lo_q;
         OP_MTHI: res = a;
         OP_MTLO: res = a;
         default: res = '0;
      endcase
   end

`ifdef ALU_OVF_EN
   logic ovf_c;
   always_comb begin
      ovf_c = 1'b0;
      if (alu_ctrl == OP_ADD)
         ovf_c = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      else if (alu_ctrl == OP_SUB)
         ovf_c = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
   end

   always_ff @(posedge clk) begin
      if (rst)           ovf <= 1'b0;
      else if (eng_done) ovf <= 1'b0;
      else if (single)   ovf <= ovf_c;
   end
`endif

   // Engine completion and single-cycle accepts are mutually exclusive: in_ready is low in FIN.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_result <= '0;
         out_zero   <= 1'b1;
         out_valid  <= 1'b0;
         hi_q       <= '0;
         lo_q       <= '0;
      end else begin
         out_valid <= single | eng_done;
         if (eng_done) begin
            hi_q       <= eng_hi;
            lo_q       <= eng_lo;
            out_result <= eng_lo;
            out_zero   <= (eng_lo == '0);
         end else if (single) begin
            out_result <= res;
            out_zero   <= (res == '0);
            if (alu_ctrl == OP_MTHI) hi_q <= a;
            if (alu_ctrl == OP_MTLO) lo_q <= a;
         end
      end
   end

endmodule

// File: tb/tb_alu_mdu.sv
// Directed self-checking bench for alu_mdu (WIDTH=32), hand-computed expectations.
module tb_alu_mdu;
   import alu_pkg::*;

   localparam int W = 32;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [4:0]    alu_ctrl;
   logic [W-1:0]  a, b;
   logic [4:0]    shamt;
   logic          out_valid;
   logic [W-1:0]  out_result;
   logic          out_zero;
   logic          busy;
`ifdef ALU_OVF_EN
   logic          ovf;
`endif

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   alu_mdu #(.WIDTH(W)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .alu_ctrl   (alu_ctrl),
      .a          (a),
      .b          (b),
      .shamt      (shamt),
      .out_valid  (out_valid),
      .out_result (out_result),
      .out_zero   (out_zero),
      .busy       (busy)
`ifdef ALU_OVF_EN
      ,
      .ovf        (ovf)
`endif
   );

   task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Drives a request now (1 time unit after an edge) and returns 1 unit after the accepting edge.
   task automatic issue(input logic [4:0] op, input logic [W-1:0] xa, input logic [W-1:0] xb,
                        input logic [4:0] sh);
      in_valid = 1'b1;
      alu_ctrl = op;
      a        = xa;
      b        = xb;
      shamt    = sh;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic single(input string tag, input logic [4:0] op, input logic [W-1:0] xa,
                         input logic [W-1:0] xb, input logic [4:0] sh, input logic [W-1:0] exp);
      issue(op, xa, xb, sh);
      check({tag, "_valid"}, W'(out_valid), W'(1));
      check(tag, out_result, exp);
      check({tag, "_zero"}, W'(out_zero), W'(exp == '0));
   endtask

   // Runs a mul/div op, pokes a request while busy (must be ignored), checks latency, LO and HI.
   task automatic muldiv(input string tag, input logic [4:0] op, input logic [W-1:0] xa,
                         input logic [W-1:0] xb, input logic [W-1:0] exp_lo,
                         input logic [W-1:0] exp_hi);
      int n = 0;
      int low = 0;
      issue(op, xa, xb, 5'd0);
      if (!in_ready) low++;
      for (int i = 1; i <= 40; i++) begin
         @(posedge clk);
         #1;
         in_valid = 1'b0;
         if (!in_ready) low++;
         if (out_valid) begin
            n = i;
            break;
         end
         if (i == 3) begin
            in_valid = 1'b1;
            alu_ctrl = OP_MTHI;
            a        = 32'h0000_0055;
         end
      end
      check({tag, "_latency"}, W'(n), W'(W + 1));
      check({tag, "_ready_low"}, W'(low), W'(W + 1));
      check({tag, "_lo"}, out_result, exp_lo);
      issue(OP_MFHI, '0, '0, 5'd0);
      check({tag, "_hi"}, out_result, exp_hi);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int vcount;
      rst      = 1'b1;
      in_valid = 1'b0;
      alu_ctrl = '0;
      a        = '0;
      b        = '0;
      shamt    = '0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      check("rst_result", out_result, '0);
      check("rst_zero", W'(out_zero), W'(1));
      check("rst_valid", W'(out_valid), W'(0));
      check("rst_ready", W'(in_ready), W'(1));
      check("rst_busy", W'(busy), W'(0));

      single("add_wrap", OP_ADD, 32'd7, 32'hFFFF_FFF9, 5'd0, 32'h0000_0000);
      @(posedge clk);
      #1;
      check("add_pulse_end", W'(out_valid), W'(0));

      single("slt", OP_SLT, 32'hFFFF_FFFF, 32'd1, 5'd0, 32'd1);
      single("sltu", OP_SLTU, 32'hFFFF_FFFF, 32'd1, 5'd0, 32'd0);

      single("sra", OP_SRA, '0, 32'h8000_0000, 5'd4, 32'hF800_0000);
      single("srl", OP_SRL, '0, 32'h8000_0000, 5'd4, 32'h0800_0000);
      single("sll", OP_SLL, '0, 32'h0000_0001, 5'd31, 32'h8000_0000);
      single("sub", OP_SUB, 32'd5, 32'd7, 5'd0, 32'hFFFF_FFFE);
      single("and", OP_AND, 32'hF0F0_00FF, 32'h0FF0_0F0F, 5'd0, 32'h00F0_000F);
      single("or", OP_OR, 32'hF0F0_00FF, 32'h0FF0_0F0F, 5'd0, 32'hFFF0_0FFF);
      single("nor", OP_NOR, 32'hF0F0_00FF, 32'h0FF0_0F0F, 5'd0, 32'h000F_F000);
      single("xnor", OP_XNOR, 32'hF0F0_00FF, 32'h0FF0_0F0F, 5'd0, 32'h00FF_F00F);
      single("lui", OP_LUI, '0, 32'h0000_1234, 5'd0, 32'h1234_0000);
      single("undef_op", 5'd31, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 32'h0000_0000);
      single("mtlo", OP_MTLO, 32'hDEAD_BEEF, '0, 5'd0, 32'hDEAD_BEEF);
      single("mflo", OP_MFLO, '0, '0, 5'd0, 32'hDEAD_BEEF);

      single("add_ovf", OP_ADD, 32'h7FFF_FFFF, 32'd1, 5'd0, 32'h8000_0000);
`ifdef ALU_OVF_EN
      check("ovf_add", W'(ovf), W'(1));
      single("add_noovf", OP_ADD, 32'd1, 32'd1, 5'd0, 32'd2);
      check("ovf_clear", W'(ovf), W'(0));
      single("sub_ovf", OP_SUB, 32'h8000_0000, 32'd1, 5'd0, 32'h7FFF_FFFF);
      check("ovf_sub", W'(ovf), W'(1));
`endif

      muldiv("mult", OP_MULT, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFF1, 32'hFFFF_FFFF);
      muldiv("multu", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFE);
      muldiv("div", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
      muldiv("div_minneg", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0000);
      muldiv("divu_zero", OP_DIVU, 32'd9, 32'd0, 32'hFFFF_FFFF, 32'h0000_0009);

      issue(OP_DIVU, 32'd100, 32'd3, 5'd0);
      repeat (9) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      check("abort_valid", W'(out_valid), W'(0));
      check("abort_ready", W'(in_ready), W'(1));
      check("abort_busy", W'(busy), W'(0));
      vcount = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         #1;
         if (out_valid) vcount++;
      end
      check("abort_no_result", W'(vcount), W'(0));
      single("abort_hi", OP_MFHI, '0, '0, 5'd0, 32'h0000_0000);
      single("abort_lo", OP_MFLO, '0, '0, 5'd0, 32'h0000_0000);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
